// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : Data-memory initiator: byte lanes, load extension, SB/SH RMW.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int unsigned DATA_BYTES = 3072
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [31:0] mem_addr,
  output logic        mem_read_enable,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic [31:0] c_data_bytes = 32'(DATA_BYTES);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;

  logic        r_is_store;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_fault;

  logic        w_accept;
  logic        w_req_fault;
  logic        w_funct3_bad;
  logic        w_misaligned;
  logic [4:0]  w_shift;
  logic [31:0] w_shifted;
  logic [31:0] w_load_result;
  logic [31:0] w_lane_mask;
  logic [31:0] w_lane_data;
  logic [31:0] w_merged;

  assign w_accept = req_valid && (r_state == S_IDLE);

  // Request legality, evaluated on the raw inputs so the fault is known at acceptance.
  always_comb begin
    w_funct3_bad = 1'b0;
    w_misaligned = 1'b0;
    if (req_is_store) begin
      w_funct3_bad = (req_funct3 >= 3'd3);
    end else begin
      w_funct3_bad = (req_funct3 == 3'd3) || (req_funct3 >= 3'd6);
    end
    if (req_funct3[1:0] == 2'd1) begin
      w_misaligned = req_addr[0];
    end else if (req_funct3[1:0] == 2'd2) begin
      w_misaligned = (req_addr[1:0] != 2'b00);
    end
    w_req_fault = (req_addr >= c_data_bytes) || w_funct3_bad || w_misaligned;
  end

  assign w_shift   = {r_addr[1:0], 3'b000};
  assign w_shifted = mem_read_data >> w_shift;

  always_comb begin
    w_load_result = 32'd0;
    case (r_funct3)
      3'd0:    w_load_result = {{24{w_shifted[7]}}, w_shifted[7:0]};
      3'd1:    w_load_result = {{16{w_shifted[15]}}, w_shifted[15:0]};
      3'd2:    w_load_result = mem_read_data;
      3'd4:    w_load_result = {24'd0, w_shifted[7:0]};
      3'd5:    w_load_result = {16'd0, w_shifted[15:0]};
      default: w_load_result = 32'd0;
    endcase
  end

  // Replicating the store data across lanes lets one mask pick the target lane.
  always_comb begin
    if (r_funct3[0]) begin
      w_lane_mask = 32'h0000_FFFF << w_shift;
      w_lane_data = {2{r_wdata[15:0]}};
    end else begin
      w_lane_mask = 32'h0000_00FF << w_shift;
      w_lane_data = {4{r_wdata[7:0]}};
    end
    w_merged = (mem_read_data & ~w_lane_mask) | (w_lane_data & w_lane_mask);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state     = r_state;
    req_ready        = 1'b0;
    resp_valid       = 1'b0;
    mem_read_enable  = 1'b0;
    mem_write_enable = 1'b0;
    mem_addr         = 32'd0;
    mem_write_data   = 32'd0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_accept) begin
          if (w_req_fault) begin
            w_next_state = S_RESP;
          end else if (req_is_store && (req_funct3 == 3'd2)) begin
            w_next_state = S_WRITE;
          end else begin
            w_next_state = S_READ;
          end
        end
      end
      S_READ: begin
        mem_read_enable = 1'b1;
        mem_addr        = {r_addr[31:2], 2'b00};
        w_next_state    = r_is_store ? S_WRITE : S_RESP;
      end
      S_WRITE: begin
        mem_write_enable = 1'b1;
        mem_addr         = {r_addr[31:2], 2'b00};
        mem_write_data   = r_wdata;
        w_next_state     = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // r_wdata doubles as the outgoing write word: SB/SH overwrite it with the merge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_is_store <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_fault    <= 1'b0;
    end else if (w_accept) begin
      r_is_store <= req_is_store;
      r_funct3   <= req_funct3;
      r_addr     <= req_addr;
      r_wdata    <= req_wdata;
      r_rdata    <= 32'd0;
      r_fault    <= w_req_fault;
    end else if (r_state == S_READ) begin
      if (r_is_store) begin
        r_wdata <= w_merged;
      end else begin
        r_rdata <= w_load_result;
      end
    end
  end

  assign resp_rdata = r_rdata;
  assign resp_fault = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Randomized and directed bench for load_store_unit vs. a reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_is_store;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [31:0] mem_addr;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int n_cmp = 0;
  int n_err = 0;
  int wr_pulses = 0;

  logic [31:0] mem     [0:767];
  logic [31:0] ref_mem [0:767];
  logic        bd_en = 1'b0;
  int          bd_idx = 0;
  logic [31:0] bd_data = 32'd0;

  load_store_unit #(.DATA_BYTES(3072)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
    .mem_addr(mem_addr), .mem_read_enable(mem_read_enable),
    .mem_write_enable(mem_write_enable), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    mem_read_data = 32'hDEAD_BEEF;
    if (mem_addr < 32'd3072) mem_read_data = mem[mem_addr[11:2]];
  end

  always @(posedge clk) begin
    if (mem_write_enable) wr_pulses <= wr_pulses + 1;
    if (bd_en) mem[bd_idx] <= bd_data;
    else if (mem_write_enable && mem_addr < 32'd3072) mem[mem_addr[11:2]] <= mem_write_data;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic poke(input int idx, input logic [31:0] data);
    @(negedge clk);
    bd_en = 1'b1; bd_idx = idx; bd_data = data;
    ref_mem[idx] = data;
    @(posedge clk);
    #1 bd_en = 1'b0;
  endtask

  // Reference: architectural effect of one request, derived from the ISA rules.
  function automatic void model(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic flt, output logic [31:0] rd,
                                output int lat, output int nrd, output int nwr);
    int size;
    int sh;
    bit legal;
    longint unsigned word, mask, val;
    legal = st ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size  = 1 << f3[1:0];
    flt   = !legal || (addr >= 32'd3072) || ((addr % size) != 0);
    rd = 32'd0; nrd = 0; nwr = 0; lat = 1;
    if (flt) return;
    sh   = 8 * int'(addr % 4);
    word = 64'(ref_mem[int'(addr >> 2)]);
    mask = ((64'd1 << (8 * size)) - 64'd1) << sh;
    if (!st) begin
      val = (word & mask) >> sh;
      if (f3 < 3'd4 && size < 4 && val[8*size-1]) val = val | ~((64'd1 << (8 * size)) - 64'd1);
      rd = val[31:0];
      lat = 2; nrd = 1;
    end else begin
      word = (word & ~mask) | ((64'(wdata) << sh) & mask);
      ref_mem[int'(addr >> 2)] = word[31:0];
      lat = (size == 4) ? 2 : 3;
      nrd = (size == 4) ? 0 : 1;
      nwr = 1;
    end
  endfunction

  task automatic do_req(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] got_rdata, output logic got_fault);
    logic        e_flt;
    logic [31:0] e_rd;
    int e_lat, e_nrd, e_nwr, lat, nrd, nwr;
    model(st, f3, addr, wdata, e_flt, e_rd, e_lat, e_nrd, e_nwr);
    got_rdata = 32'd0; got_fault = 1'b0;
    lat = 0; nrd = 0; nwr = 0;
    @(negedge clk);
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom;
    for (int c = 1; c <= 8 && lat == 0; c++) begin
      @(negedge clk);
      if (mem_read_enable) begin
        nrd++;
        check("rd_addr", mem_addr, addr & 32'hFFFF_FFFC);
      end
      if (mem_write_enable) begin
        nwr++;
        check("wr_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("wr_data", mem_write_data, ref_mem[int'(addr >> 2)]);
      end
      if (resp_valid) begin
        lat = c;
        got_rdata = resp_rdata;
        got_fault = resp_fault;
        check("resp_vs_ready", {31'd0, req_ready}, 32'd0);
      end
    end
    check("latency", lat, e_lat);
    check("fault", {31'd0, got_fault}, {31'd0, e_flt});
    check("rdata", got_rdata, e_rd);
    check("n_reads", nrd, e_nrd);
    check("n_writes", nwr, e_nwr);
    if (lat != 0) begin
      @(negedge clk);
      check("resp_one_cycle", {31'd0, resp_valid}, 32'd0);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'd3072 + $urandom_range(0, 16);
    return $urandom_range(0, 3071);
  endfunction

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  initial begin
    logic [31:0] r;
    logic        f;
    int          pre;
    int          accepted;
    int          nresp;
    int          diffs;
    req_t        q[$];
    req_t        cur;
    logic        e_flt;
    logic [31:0] e_rd;
    int          e_lat, e_nrd, e_nwr;

    reset = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_fault", {31'd0, resp_fault}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("rst_mem_wdata", mem_write_data, 32'd0);
    for (int i = 0; i < 768; i++) poke(i, $urandom);
    @(negedge clk);
    reset = 1'b0;

    // Directed cases from the worked examples
    poke(5, 32'hFFFF_FFE0); poke(6, 32'h1122_3344); poke(7, 32'h0);
    do_req(1'b0, 3'd0, 32'h14, 32'd0, r, f); check("lb_14", r, 32'hFFFF_FFE0);
    do_req(1'b0, 3'd4, 32'h14, 32'd0, r, f); check("lbu_14", r, 32'h0000_00E0);
    do_req(1'b0, 3'd1, 32'h16, 32'd0, r, f); check("lh_16", r, 32'hFFFF_FFFF);
    do_req(1'b0, 3'd5, 32'h16, 32'd0, r, f); check("lhu_16", r, 32'h0000_FFFF);
    do_req(1'b1, 3'd0, 32'h19, 32'hAB, r, f); check("sb_19_mem", mem[6], 32'h1122_AB44);
    do_req(1'b1, 3'd1, 32'h1E, 32'h1234_BEEF, r, f); check("sh_1e_mem", mem[7], 32'hBEEF_0000);
    do_req(1'b1, 3'd2, 32'h20, 32'hCAFE_F00D, r, f); check("sw_20_mem", mem[8], 32'hCAFE_F00D);
    do_req(1'b0, 3'd2, 32'h15, 32'd0, r, f);  check("lw_15_fault", {31'd0, f}, 32'd1);
    do_req(1'b1, 3'd1, 32'h1F, 32'd0, r, f);  check("sh_1f_fault", {31'd0, f}, 32'd1);
    do_req(1'b0, 3'd0, 32'hC00, 32'd0, r, f); check("lb_c00_fault", {31'd0, f}, 32'd1);
    do_req(1'b0, 3'd3, 32'h10, 32'd0, r, f);  check("ld_f3_3_fault", {31'd0, f}, 32'd1);

    // Reset while an SB sits in READ: the write must be abandoned
    poke(6, 32'h1122_3344);
    pre = wr_pulses;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b1; req_funct3 = 3'd0; req_addr = 32'h19; req_wdata = 32'hAB;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_in_read", {31'd0, mem_read_enable}, 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_en", {30'd0, mem_read_enable, mem_write_enable}, 32'd0);
    check("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    check("mid_rst_resp", {30'd0, resp_valid, resp_fault}, 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_addr", mem_addr, 32'd0);
    check("mid_rst_wdata", mem_write_data, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    nresp = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) nresp++;
    end
    check("mid_rst_no_resp", nresp, 32'd0);
    check("mid_rst_no_write", wr_pulses - pre, 32'd0);
    check("mid_rst_word", mem[6], 32'h1122_3344);

    // Randomized single requests
    for (int i = 0; i < 80; i++)
      do_req(1'($urandom), 3'($urandom), rand_addr(), $urandom, r, f);

    // Back-to-back with req_valid held high, fields churning every cycle
    accepted = 0; nresp = 0;
    for (int c = 0; c < 400 && !(accepted == 15 && nresp == 15); c++) begin
      @(negedge clk);
      if (mem_read_enable && mem_write_enable) check("b2b_en_excl", 32'd1, 32'd0);
      if (resp_valid) begin
        nresp++;
        check("b2b_resp_vs_ready", {31'd0, req_ready}, 32'd0);
        if (q.size() == 0) begin
          check("b2b_unexpected_resp", 32'd1, 32'd0);
        end else begin
          cur = q.pop_front();
          model(cur.st, cur.f3, cur.addr, cur.wdata, e_flt, e_rd, e_lat, e_nrd, e_nwr);
          check("b2b_fault", {31'd0, resp_fault}, {31'd0, e_flt});
          check("b2b_rdata", resp_rdata, e_rd);
        end
      end
      if (accepted >= 15) begin
        req_valid = 1'b0;
      end else begin
        req_valid = 1'b1; req_is_store = 1'($urandom); req_funct3 = 3'($urandom);
        req_addr = rand_addr(); req_wdata = $urandom;
        if (req_ready) begin
          q.push_back('{req_is_store, req_funct3, req_addr, req_wdata});
          accepted++;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_accepted", accepted, 32'd15);
    check("b2b_resp_count", nresp, 32'd15);
    repeat (3) @(negedge clk);

    diffs = 0;
    for (int i = 0; i < 768; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check("final_mem_words_differing", diffs, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
